alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4, command queue entries (power of 2, >=2).
REQ-002 Parameter TAG_W, default 2, width of caller-supplied command tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 cmd_valid  input  1  upstream command offered.
REQ-006 cmd_ready  output  1  queue can accept; high iff count < DEPTH.
REQ-007 cmd_opcode  input  3  ALU opcode; cmd_a, cmd_b  input  5 each  operands.
REQ-008 cmd_tag  input  TAG_W  tag returned with the matching response.
REQ-009 alu_opcode  output  3; alu_in1, alu_in2  output  5 each  registered ALU drive.
REQ-010 alu_rst  output  1  active-high ALU reset, equal to ~rst (combinational).
REQ-011 alu_result  input  6  registered result from ALU, valid one clk after sampling inputs.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_result  output  6; rsp_tag  output  TAG_W; rsp_opcode  output  3  response payload.
REQ-014 count  output  clog2(DEPTH)+1  commands queued, excluding the one in flight.

Function
REQ-015 Command accepted on an edge where cmd_valid && cmd_ready; opcode, a, b, tag written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
REQ-016 cmd_valid while full: no write, no pointer/count change, no error flag.
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-018 IDLE: if count > 0, pop head into alu_opcode/alu_in1/alu_in2 plus internal tag/opcode regs, rd_ptr advances (wraps), -> ISSUE; else stay IDLE.
REQ-019 ISSUE: ALU inputs held stable one full cycle (ALU samples at end of cycle), -> WAIT.
REQ-020 WAIT: at end of cycle, capture alu_result into rsp_result, -> RESP.
REQ-021 RESP: rsp_valid = 1; payload constant while rsp_valid && !rsp_ready; on rsp_ready edge -> IDLE.
REQ-022 rsp_valid is 1 only in RESP; alu_* outputs hold last issued values outside ISSUE/WAIT.
REQ-023 Minimum latency: accept edge N into empty queue with FSM in IDLE -> pop at N+1, rsp_valid high from N+3; one command per 4 cycles at best.
REQ-024 Simultaneous push and pop in one edge: count unchanged, both pointers advance; empty-to-push and pop never occur in the same edge (pop requires count > 0 before the edge).
REQ-025 Responses returned strictly in accept order; rsp_tag equals tag of that command.
REQ-026 rsp_result is the 6-bit ALU output unmodified; no width extension or truncation.
REQ-027 Upstream acceptance continues during ISSUE/WAIT/RESP while count < DEPTH.

Reset
REQ-028 rst = 0 at an edge: FSM -> IDLE, pointers and count -> 0, queue contents discarded.
REQ-029 Reset values: cmd_ready 1 (once rst = 1), rsp_valid 0, rsp_result 0, rsp_tag 0, rsp_opcode 0, alu_opcode 0, alu_in1 0, alu_in2 0, count 0.
REQ-030 Reset mid-operation (any state, including RESP with rsp_valid pending) drops in-flight command; no response issued for it.
REQ-031 cmd_valid during reset is not accepted; alu_rst = 1 throughout reset.

Verification
REQ-032 Single add: opcode 000, a=5, b=3, tag=1, rsp_ready=1 -> rsp_valid at accept+3, rsp_result=8, rsp_tag=1, rsp_opcode=000.
REQ-033 Sub underflow: opcode 001, a=3, b=5 -> rsp_result=6'h3E; opcode 000, a=31, b=31 -> rsp_result=62.
REQ-034 Fill: 5 back-to-back commands, DEPTH=4, rsp_ready=0 -> first popped, count reaches 4, cmd_ready=0, 6th cmd_valid ignored; then rsp_ready=1 -> 5 responses in tag order 0,1,2,3,0.
REQ-035 Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and payload stable all 10 cycles; release -> IDLE next edge.
REQ-036 Reset in WAIT with 2 queued: rst=0 one edge -> rsp_valid=0, count=0, cmd_ready=1 after release, no stale response ever appears.
REQ-037 Random ops/operands/backpressure against an ALU model -> every response matches model result and tag, none lost or duplicated.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// Command queue and sequencer in front of a registered 5-bit ALU.
// Commands are buffered, issued one at a time, and answered in accept order with their tag.
module alu_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [4:0]               cmd_a,
    input  logic [4:0]               cmd_b,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [2:0]               alu_opcode,
    output logic [4:0]               alu_in1,
    output logic [4:0]               alu_in2,
    output logic                     alu_rst,
    input  logic [5:0]               alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [5:0]               rsp_result,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [2:0]               rsp_opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [2:0]       q_op  [DEPTH];
    logic [4:0]       q_a   [DEPTH];
    logic [4:0]       q_b   [DEPTH];
    logic [TAG_W-1:0] q_tag [DEPTH];
    logic [TAG_W-1:0] tag_fl;
    logic [2:0]       op_fl;
    logic             push;
    logic             pop;

    // Gating with rst keeps a command offered during reset from looking accepted.
    assign cmd_ready = rst && (count < FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign rsp_valid = (state == RESP);
    assign alu_rst   = ~rst;

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]  <= cmd_opcode;
            q_a[wr_ptr]   <= cmd_a;
            q_b[wr_ptr]   <= cmd_b;
            q_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_opcode <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            tag_fl     <= '0;
            op_fl      <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_opcode <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // The ALU samples its inputs at the end of ISSUE; its result is ready by the end of WAIT.
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_opcode <= q_op[rd_ptr];
                        alu_in1    <= q_a[rd_ptr];
                        alu_in2    <= q_b[rd_ptr];
                        tag_fl     <= q_tag[rd_ptr];
                        op_fl      <= q_op[rd_ptr];
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    rsp_result <= alu_result;
                    rsp_tag    <= tag_fl;
                    rsp_opcode <= op_fl;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: registered ALU model, table vectors, scoreboard and corner-case sequences.
module tb_alu_cmd_seq;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [4:0]       cmd_a;
    logic [4:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [2:0]       alu_opcode;
    logic [4:0]       alu_in1;
    logic [4:0]       alu_in2;
    logic             alu_rst;
    logic [5:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [5:0]       rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic [2:0]       rsp_opcode;
    logic [2:0]       count;

    logic bp_en = 1'b0;
    logic bp_rand = 1'b0;
    logic rsp_ready_man = 1'b0;
    assign rsp_ready = bp_en ? bp_rand : rsp_ready_man;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_rst(alu_rst),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_opcode(rsp_opcode), .count(count)
    );

    function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {1'b0, ~a};
            default: return {1'b0, b};
        endcase
    endfunction

    // External ALU: result registered one clock after it samples its inputs.
    always @(posedge clk) begin
        if (alu_rst) alu_result <= 6'd0;
        else         alu_result <= alu_model(alu_opcode, alu_in1, alu_in2);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bp_rand = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic [2:0]       op;
        logic [4:0]       a;
        logic [4:0]       b;
        logic [TAG_W-1:0] tag;
        logic [5:0]       res;
    } vec_t;

    typedef struct {
        logic [5:0]       res;
        logic [TAG_W-1:0] tag;
        logic [2:0]       op;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rsp_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Response monitor: a transfer happens on the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual tag=%0d result=%0h required none", rsp_tag, rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
                check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                check("rsp_opcode", 32'(rsp_opcode), 32'(mon_e.op));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [TAG_W-1:0] tag, input logic [5:0] res);
        exp_t e;
        bit   done;
        done = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready && rst) begin
                e.res = res;
                e.tag = tag;
                e.op  = op;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag=%0d accepted=0 required=1", tag);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    vec_t tbl[9];
    int   base;
    bit   stable;
    bit   seen;
    logic [5:0]       h_res;
    logic [TAG_W-1:0] h_tag;
    logic [2:0]       h_op;

    initial begin
        tbl[0] = '{3'd0, 5'd5,  5'd3,  2'd1, 6'd8};
        tbl[1] = '{3'd1, 5'd3,  5'd5,  2'd2, 6'h3E};
        tbl[2] = '{3'd0, 5'd31, 5'd31, 2'd3, 6'd62};
        tbl[3] = '{3'd1, 5'd0,  5'd1,  2'd0, 6'h3F};
        tbl[4] = '{3'd2, 5'h1A, 5'h0F, 2'd1, 6'h0A};
        tbl[5] = '{3'd3, 5'h10, 5'h03, 2'd2, 6'h13};
        tbl[6] = '{3'd4, 5'h1F, 5'h15, 2'd3, 6'h0A};
        tbl[7] = '{3'd0, 5'd0,  5'd0,  2'd0, 6'd0};
        tbl[8] = '{3'd1, 5'd31, 5'd0,  2'd1, 6'h1F};

        // Reset with a command offered throughout.
        rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_opcode = 3'd0;
        cmd_a = 5'd7;
        cmd_b = 5'd9;
        cmd_tag = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        check("alu_rst_in_reset", 32'(alu_rst), 32'd1);
        check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        check("count_in_reset", 32'(count), 32'd0);
        rst = 1'b1;
        cmd_valid = 1'b0;
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        check("reset_rsp_opcode", 32'(rsp_opcode), 32'd0);
        check("reset_alu_ins", 32'({alu_opcode, alu_in1, alu_in2}), 32'd0);
        check("alu_rst_released", 32'(alu_rst), 32'd0);
        @(posedge clk);
        #1;
        check("no_accept_in_reset", 32'(count), 32'd0);

        // Minimum latency on a single add.
        rsp_ready_man = 1'b1;
        send(3'd0, 5'd5, 5'd3, 2'd1, 6'd8);
        check("lat_count_after_accept", 32'(count), 32'd1);
        @(posedge clk); #1;
        check("lat_valid_n1", 32'(rsp_valid), 32'd0);
        check("lat_count_n1", 32'(count), 32'd0);
        check("lat_alu_drive", 32'({alu_opcode, alu_in1, alu_in2}), 32'({3'd0, 5'd5, 5'd3}));
        @(posedge clk); #1;
        check("lat_valid_n2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_n3", 32'(rsp_valid), 32'd1);
        check("lat_result_n3", 32'(rsp_result), 32'd8);
        drain("lat_drain");

        // Table vectors, back to back.
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].res);
        end
        drain("table_drain");

        // Fill the queue under backpressure.
        rsp_ready_man = 1'b0;
        base = rsp_seen;
        for (int i = 0; i < 5; i++) begin
            send(3'd0, 5'(i), 5'd1, 2'(i), 6'(i + 1));
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_opcode = 3'd1;
        cmd_a = 5'd9;
        cmd_b = 5'd9;
        cmd_tag = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("full_ignored_count", 32'(count), 32'd4);
        rsp_ready_man = 1'b1;
        drain("fill_drain");
        check("fill_rsp_total", 32'(rsp_seen - base), 32'd5);

        // Hold a response for ten cycles.
        rsp_ready_man = 1'b0;
        send(3'd4, 5'h1F, 5'h15, 2'd2, 6'h0A);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_reached", 32'(rsp_valid), 32'd1);
        h_res = rsp_result;
        h_tag = rsp_tag;
        h_op  = rsp_opcode;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_result !== h_res || rsp_tag !== h_tag || rsp_opcode !== h_op)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        rsp_ready_man = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", 32'(rsp_valid), 32'd0);
        drain("bp_drain");

        // Reset while one command is in WAIT and two are queued.
        send(3'd0, 5'd1, 5'd1, 2'd1, 6'd2);
        send(3'd0, 5'd2, 5'd2, 2'd2, 6'd4);
        send(3'd0, 5'd3, 5'd3, 2'd3, 6'd6);
        check("wait_count_before_rst", 32'(count), 32'd2);
        check("wait_no_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Random traffic with random backpressure.
        base = rsp_seen;
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]       r_op;
            logic [4:0]       r_a;
            logic [4:0]       r_b;
            logic [TAG_W-1:0] r_tag;
            r_op  = 3'($urandom_range(0, 7));
            r_a   = 5'($urandom_range(0, 31));
            r_b   = 5'($urandom_range(0, 31));
            r_tag = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(r_op, r_a, r_b, r_tag, alu_model(r_op, r_a, r_b));
        end
        bp_en = 1'b0;
        rsp_ready_man = 1'b1;
        drain("rand_drain");
        check("rand_rsp_total", 32'(rsp_seen - base), 32'd60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
